// File: rtl/core_types_pkg.sv
// -----------------------------------------------------------------------------
// core_types_pkg
// Shared types for the integer execution path:
//   XLEN             - default datapath width
//   alu_op_t         - operation code produced by the ALU-control decoder
//   alu_iter_state_t - sequencing state of the iterative ALU
//   is_shift_op()    - true for the ops that run through the bit-serial shifter
// -----------------------------------------------------------------------------
package core_types_pkg;

    localparam int XLEN = 32;

    // Encodings 10..15 are unused; the ALU completes them with a zero result.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_iter_state_t;

    function automatic logic is_shift_op(input alu_op_t op);
        logic res;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_simple.sv
// -----------------------------------------------------------------------------
// alu_simple
// Purely combinational single-cycle ALU operations.
//   in_op  - operation code
//   in_a   - operand A
//   in_b   - operand B
//   result - ADD/SUB/AND/OR/XOR/SLT/SLTU result; zero for shifts and for
//            undefined encodings (shifts are sequenced by alu_iter)
// -----------------------------------------------------------------------------
module alu_simple
    import core_types_pkg::*;
#(
    parameter int XLEN = core_types_pkg::XLEN
) (
    input  alu_op_t          in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    output logic [XLEN-1:0]  result
);

    // Single-cycle operation select; arithmetic wraps modulo 2^XLEN.
    always_comb begin
        result = {XLEN{1'b0}};
        case (in_op)
            OP_ADD:  result = in_a + in_b;
            OP_SUB:  result = in_a - in_b;
            OP_AND:  result = in_a & in_b;
            OP_OR:   result = in_a | in_b;
            OP_XOR:  result = in_a ^ in_b;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            default: result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// Iterative ALU: single-cycle ops finish with latency 1, shifts by n (1..31)
// shift one bit per clock and finish with latency n+1.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - request handshake (in_ready only in IDLE)
//   in_op, in_a, in_b     - operation and operands; shift amount is in_b[4:0]
//   flush                 - synchronous abort, overrides every other event
//   out_valid / out_ready - result handshake (out_valid only in DONE)
//   out_result            - last computed result, held stable in DONE
// -----------------------------------------------------------------------------
module alu_iter
    import core_types_pkg::*;
#(
    parameter int XLEN = core_types_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result
);

    alu_iter_state_t  state_r;
    alu_iter_state_t  state_next_s;
    logic [4:0]       cnt_r;
    logic [XLEN-1:0]  acc_r;
    logic [XLEN-1:0]  result_r;
    alu_op_t          shop_r;

    logic [4:0]       shamt_s;
    logic             shift_req_s;
    logic             accept_s;
    logic [XLEN-1:0]  simple_res_s;
    logic [XLEN-1:0]  start_res_s;
    logic [XLEN-1:0]  acc_shift_s;

    alu_simple #(.XLEN(XLEN)) u_simple (
        .in_op  (in_op),
        .in_a   (in_a),
        .in_b   (in_b),
        .result (simple_res_s)
    );

    assign shamt_s     = in_b[4:0];
    assign shift_req_s = is_shift_op(in_op) && (shamt_s != 5'd0);
    assign accept_s    = in_valid && (state_r == IDLE) && !flush;

    // Outputs decode directly from the state register and the result register.
    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == DONE);
    assign out_result = result_r;

    // Result captured at accept: a zero-distance shift passes operand A through.
    always_comb begin
        start_res_s = simple_res_s;
        if (is_shift_op(in_op)) begin
            start_res_s = in_a;
        end else begin
            start_res_s = simple_res_s;
        end
    end

    // One-bit step of the shifter for the op latched at accept.
    always_comb begin
        acc_shift_s = acc_r;
        case (shop_r)
            OP_SLL:  acc_shift_s = {acc_r[XLEN-2:0], 1'b0};
            OP_SRL:  acc_shift_s = {1'b0, acc_r[XLEN-1:1]};
            OP_SRA:  acc_shift_s = {acc_r[XLEN-1], acc_r[XLEN-1:1]};
            default: acc_shift_s = acc_r;
        endcase
    end

    // Next-state logic; flush wins over accept, shift progress and handshake.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (shift_req_s) begin
                            state_next_s = SHIFT;
                        end else begin
                            state_next_s = DONE;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                SHIFT: begin
                    // <= 1 rather than == 1 so a corrupted zero count cannot stall here
                    if (cnt_r <= 5'd1) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers: operand capture, per-bit shifting, result update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 5'd0;
            acc_r    <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
            shop_r   <= OP_ADD;
        end else if (flush) begin
            cnt_r <= 5'd0;
        end else if (accept_s) begin
            if (shift_req_s) begin
                acc_r  <= in_a;
                cnt_r  <= shamt_s;
                shop_r <= in_op;
            end else begin
                result_r <= start_res_s;
            end
        end else if (state_r == SHIFT) begin
            acc_r <= acc_shift_s;
            cnt_r <= cnt_r - 5'd1;
            if (cnt_r <= 5'd1) begin
                result_r <= acc_shift_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// -----------------------------------------------------------------------------
// tb_alu_iter
// Self-checking bench for alu_iter: directed vector table, hand-written flush
// and reset sequences, and randomized operations against a behavioural model.
// -----------------------------------------------------------------------------
module tb_alu_iter;
    import core_types_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    alu_op_t      in_op;
    logic [31:0]  in_a;
    logic [31:0]  in_b;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_result;

    int n_vec;
    int n_err;

    alu_iter #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        alu_op_t      op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  res;
        int           lat;
        int           hold;
        string        nm;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on the operation's definition.
    function automatic logic [31:0] model_res(input alu_op_t op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return 32'(signed'(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input alu_op_t op, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && sh != 0) return sh + 1;
        return 1;
    endfunction

    // Issue one op, measure latency, hold the result for 'hold' cycles, then consume.
    task automatic run_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic [31:0] exp_res, input int exp_lat,
                          input string nm);
        int lat;
        logic busy_ok;
        check({nm, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_busy_not_ready"}, {31'd0, busy_ok}, 32'd1);
        check({nm, "_result"}, out_result, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_held_valid"}, {31'd0, out_valid}, 32'd1);
            check({nm, "_held_result"}, out_result, exp_res);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_valid_after_take"}, {31'd0, out_valid}, 32'd0);
        check({nm, "_ready_after_take"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        alu_op_t rop;
        logic [31:0] ra, rb;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = OP_ADD; in_a = 32'd0; in_b = 32'd0;
        flush = 1'b0; out_ready = 1'b0;

        tbl[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1,  0, "add_wrap"};
        tbl[1]  = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1,  1, "sub_wrap"};
        tbl[2]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1,  0, "and"};
        tbl[3]  = '{OP_OR,   32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1,  0, "or"};
        tbl[4]  = '{OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1,  0, "xor"};
        tbl[5]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1,  0, "slt_neg"};
        tbl[6]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1,  0, "sltu_big"};
        tbl[7]  = '{OP_SLL,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1,  0, "sll_zero"};
        tbl[8]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5,  0, "sra_4"};
        tbl[9]  = '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32, 3, "srl_31_hold"};
        tbl[10] = '{OP_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32, 0, "sll_31"};
        tbl[11] = '{OP_SLL,  32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 2,  0, "sll_upper_b"};
        tbl[12] = '{OP_SRA,  32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 3,  0, "sra_pos"};
        tbl[13] = '{alu_op_t'(4'd12), 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 1, 0, "undef_op"};

        // Reset state, observed while reset is held.
        #3;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_result", out_result, 32'd0);
        #20;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].res, tbl[i].lat, tbl[i].nm);
        end

        // Flush in the third SHIFT cycle of SLL by 10.
        in_op = OP_SLL; in_a = 32'h0000_0001; in_b = 32'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flush_pre_busy", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_to_idle", {31'd0, in_ready}, 32'd1);
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("flush_no_valid", 32'(seen), 32'd0);
        run_op(OP_ADD, 32'd5, 32'd7, 0, 32'd12, 1, "add_after_flush");

        // Flush while a request is offered: nothing accepted.
        in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", {31'd0, out_valid}, 32'd0);

        // Flush in DONE drops the held result.
        in_op = OP_XOR; in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("done_before_flush", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_drops_done", {31'd0, out_valid}, 32'd0);
        check("flush_done_ready", {31'd0, in_ready}, 32'd1);

        // Reset pulsed in DONE: out_valid drops without a clock edge.
        in_op = OP_ADD; in_a = 32'd9; in_b = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_done_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, out_valid}, 32'd0);
        check("rst_async_result", out_result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-SHIFT: no result appears afterwards.
        in_op = OP_SRL; in_a = 32'hFFFF_FFFF; in_b = 32'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check("rst_shift_abandon", 32'(seen), 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            rop = alu_op_t'(4'($urandom_range(0, 15)));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 3 == 0) ra = {1'b1, ra[30:0]};
            run_op(rop, ra, rb, $urandom_range(0, 2), model_res(rop, ra, rb),
                   model_lat(rop, rb), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port in_op  input  alu_op_t  operation from the ALU-control decoder.
REQ-007 SHALL have port in_a  input  XLEN  operand A (rs1).
REQ-008 SHALL have port in_b  input  XLEN  operand B (rs2 or immediate); shift amount is in_b[4:0].
REQ-009 SHALL have port flush  input  1  synchronous abort; discards any in-flight or held result.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_result  output  XLEN  operation result.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 SHALL accept a request on a rising edge where in_valid && in_ready && !flush, capturing in_op, in_a, in_b[4:0].
REQ-015 ADD, SUB, AND, OR, XOR SHALL compute modulo 2^XLEN, carry/overflow discarded; state IDLE -> DONE; out_valid high the cycle after accept (latency 1).
REQ-016 SLT SHALL yield 1 if signed(in_a) < signed(in_b), else 0, zero-extended; SLTU the same with unsigned compare; latency 1.
REQ-017 SLL, SRL, SRA with shamt 0 SHALL go directly to DONE with result = in_a (latency 1).
REQ-018 SLL, SRL, SRA with shamt n (1..31) SHALL load accumulator = in_a, counter = n, enter SHIFT; each SHIFT edge shifts by exactly one bit and decrements counter; on the edge where counter goes 1 -> 0, state -> DONE; out_valid visible n+1 cycles after accept.
REQ-019 SRL SHALL shift in 0; SRA SHALL replicate bit XLEN-1; SLL SHALL shift in 0 at bit 0.
REQ-020 In DONE, out_result SHALL hold stable until out_valid && out_ready; on that edge state -> IDLE (no same-cycle accept; peak throughput one op per two cycles).
REQ-021 out_result SHALL be don't-care-free: equal to the last computed result outside DONE (no X propagation).
REQ-022 flush SHALL take priority over every other event: on any edge with flush=1, state -> IDLE, counter cleared, no request accepted, any held result dropped without out_valid handshake.
REQ-023 in_valid while in SHIFT or DONE SHALL be ignored (in_ready low); requester holds inputs until accepted.
REQ-024 An alu_op_t encoding outside the defined set SHALL complete with latency 1 and result 0.

Reset
REQ-025 On rst_n low, asynchronously: state = IDLE, counter = 0, accumulator/out_result = 0, out_valid = 0, in_ready = 1 after release.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no result appears after release.

Structure
REQ-027 alu_op_t and XLEN SHALL come from core_types_pkg; the iterator state enum (IDLE, SHIFT, DONE) SHALL be declared in core_types_pkg as alu_iter_state_t.
REQ-028 Single-cycle ops SHALL be computed in one combinational sub-module alu_simple (in_op, in_a, in_b -> result); shift sequencing stays in alu_iter.

Verification
REQ-029 ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid one cycle after accept, result 0x00000000, next cycle in_ready=1.
REQ-030 SRA a=0x80000000, b=4 -> out_valid 5 cycles after accept, result 0xF8000000; in_ready low for those cycles.
REQ-031 SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same operands -> 0; SLL b=0 with a=0x1234 -> 0x1234 at latency 1.
REQ-032 SRL a=0x80000000, b=31, out_ready low for 3 cycles after DONE -> result 0x00000001 held stable, completes on out_ready.
REQ-033 flush asserted in third SHIFT cycle of SLL b=10 -> IDLE next cycle, out_valid never asserted, next ADD completes normally.
REQ-034 rst_n pulsed low in DONE -> out_valid drops immediately (asynchronously), in_ready=1 after release.
